ex_reg: RTL
===========

Name: ex_reg

Overview:
- EX/MEM pipeline register that receives the ALU's result and overflow flag and carries the EX-stage payload into the MEM stage.
- Converts a signed ALU overflow into an overflow exception and suppresses that instruction's register write-back and memory access.
- Handles stall, flush and interrupt squash, and keeps a saturating overflow event counter for debug.
- Sits between the ALU/EX datapath and the MEM stage.

Parameters:
- WORD_W, 32, data/address word width
- OFCNT_W, 16, width of the overflow event counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold all registers this cycle
- flush  in  1  squash: load a bubble
- int_detect  in  1  interrupt taken: load a bubble
- ofcnt_clr  in  1  synchronous clear of the overflow counter
- id_en  in  1  incoming instruction valid
- id_pc  in  WORD_W  incoming PC
- id_alu_op  in  4  ALU opcode of the incoming instruction
- alu_out  in  WORD_W  ALU result
- alu_of  in  1  ALU signed-overflow flag
- id_br_flag  in  1  branch taken
- id_mem_op  in  2  memory opcode
- id_mem_wr_data  in  WORD_W  store data
- id_ctrl_op  in  2  control opcode
- id_dst_addr  in  5  destination GPR
- id_gpr_we_  in  1  GPR write enable, active-low
- id_exp_code  in  3  upstream exception code
- ex_en  out  1  registered valid
- ex_pc  out  WORD_W  registered PC
- ex_out  out  WORD_W  registered ALU result
- ex_br_flag  out  1
- ex_mem_op  out  2
- ex_mem_wr_data  out  WORD_W
- ex_ctrl_op  out  2
- ex_dst_addr  out  5
- ex_gpr_we_  out  1  active-low
- ex_exp_code  out  3
- fwd_data  out  WORD_W  combinational alu_out, for ID-stage forwarding
- ofcnt  out  OFCNT_W  saturating count of overflow exceptions raised

Behaviour:
- Reset values (asynchronous, active-high):
  - ex_en=0, ex_pc=0, ex_out=0, ex_br_flag=0
  - ex_mem_op=MEM_OP_NOP, ex_mem_wr_data=0, ex_ctrl_op=CTRL_OP_NOP
  - ex_dst_addr=0, ex_gpr_we_=1, ex_exp_code=EXP_NO_EXP
  - ofcnt=0
- Latency: one cycle from inputs to ex_* outputs. fwd_data has zero latency.
- Priority on each rising edge: reset > stall > (flush | int_detect) > normal load.
- stall=1: every register holds, ofcnt included. Flush and int_detect are ignored in that cycle.
- Bubble (flush or int_detect, no stall):
  - ex_en=0, ex_br_flag=0, ex_mem_op=NOP, ex_ctrl_op=NOP
  - ex_gpr_we_=1, ex_exp_code=EXP_NO_EXP
  - ex_pc, ex_out and ex_dst_addr load normally (don't-care).
- Normal load: all fields are copied. The overflow condition is ovf = id_en & alu_of & (id_alu_op==ALU_OP_ADDS | id_alu_op==ALU_OP_SUBS).
- When ovf=1:
  - ex_exp_code=EXP_OVERFLOW, ex_gpr_we_=1, ex_mem_op=NOP, ex_ctrl_op=NOP, ex_br_flag=0
  - ex_pc and ex_out still load, so the handler sees the faulting PC.
- A non-zero id_exp_code takes precedence over overflow: it is passed through and ovf is not recorded.
- id_en=0 with no stall/flush: fields load as given. Overflow is never raised.
- ofcnt:
  - Increments by 1 on a normal-load cycle with ovf=1 and id_exp_code=0.
  - Saturates at all-ones.
  - ofcnt_clr sets it to 0 and wins over a simultaneous increment, but stall still wins over clr.
- Reset mid-operation clears immediately, with no dependence on clk.

Decomposition:
- Shared package/header holds:
  - ALU_OP_* encodings (4-bit)
  - MEM_OP_NOP and the other MEM_OP_* codes (2-bit)
  - CTRL_OP_NOP (2-bit)
  - EXP_NO_EXP=3'h0 and EXP_OVERFLOW=3'h3
  - WORD_W and REG_ADDR_W=5
- One natural sub-module, ex_ofcnt, holding the saturating counter with clr/stall.
- Everything else is flat.

Test Plan:
- Reset asserted mid-cycle with clk stopped → all outputs reach reset values at once. ex_gpr_we_=1, ofcnt=0.
- Normal load: ADDU, alu_out=0x0000_0005, id_pc=0x100, id_gpr_we_=0, id_dst_addr=3 → next cycle ex_en=1, ex_out=5, ex_pc=0x100, ex_gpr_we_=0, ex_exp_code=0.
- ADDS, alu_out=0x8000_0000, alu_of=1, id_en=1, id_gpr_we_=0, id_mem_op≠NOP → ex_exp_code=3'h3, ex_gpr_we_=1, ex_mem_op=NOP, ex_out=0x8000_0000, ofcnt=1.
- Same overflow stimulus with stall=1 for 3 cycles → outputs and ofcnt frozen. On release, one load occurs and ofcnt increments exactly once.
- flush=1 together with ADDS overflow → bubble (ex_en=0, ex_exp_code=0), ofcnt unchanged. flush=1 with stall=1 → hold.
- Force ofcnt to 0xFFFF (OFCNT_W=16), then one more overflow → stays 0xFFFF. ofcnt_clr together with an overflow → 0.

Source files
------------

// File: rtl/ex_reg_pkg.sv
// Shared encodings and widths for the EX/MEM pipeline register.
package ex_reg_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [3:0] {
    ALU_OP_NOP  = 4'h0,
    ALU_OP_AND  = 4'h1,
    ALU_OP_OR   = 4'h2,
    ALU_OP_XOR  = 4'h3,
    ALU_OP_ADDS = 4'h4,
    ALU_OP_ADDU = 4'h5,
    ALU_OP_SUBS = 4'h6,
    ALU_OP_SUBU = 4'h7,
    ALU_OP_SHRL = 4'h8,
    ALU_OP_SHLL = 4'h9
  } alu_op_e;

  typedef enum logic [1:0] {
    MEM_OP_NOP = 2'h0,
    MEM_OP_LDW = 2'h1,
    MEM_OP_STW = 2'h2
  } mem_op_e;

  typedef enum logic [1:0] {
    CTRL_OP_NOP  = 2'h0,
    CTRL_OP_WRCR = 2'h1,
    CTRL_OP_EXRT = 2'h2
  } ctrl_op_e;

  typedef enum logic [2:0] {
    EXP_NO_EXP     = 3'h0,
    EXP_EXT_INT    = 3'h1,
    EXP_UNDEF_INSN = 3'h2,
    EXP_OVERFLOW   = 3'h3,
    EXP_MISS_ALIGN = 3'h4,
    EXP_TRAP       = 3'h5,
    EXP_PRV_VIO    = 3'h6
  } exp_code_e;

  // Only the signed add/subtract opcodes can raise an overflow exception.
  function automatic logic is_signed_arith(input logic [3:0] op);
    return (op == ALU_OP_ADDS) || (op == ALU_OP_SUBS);
  endfunction

endpackage

// File: rtl/ex_reg_if.sv
// EX-stage payload going in and the registered MEM-stage payload coming out.
interface ex_reg_if #(
  parameter int WORD_W  = 32,
  parameter int OFCNT_W = 16
);

  logic              id_en;
  logic [WORD_W-1:0] id_pc;
  logic [3:0]        id_alu_op;
  logic [WORD_W-1:0] alu_out;
  logic              alu_of;
  logic              id_br_flag;
  logic [1:0]        id_mem_op;
  logic [WORD_W-1:0] id_mem_wr_data;
  logic [1:0]        id_ctrl_op;
  logic [4:0]        id_dst_addr;
  logic              id_gpr_we_;
  logic [2:0]        id_exp_code;

  logic               ex_en;
  logic [WORD_W-1:0]  ex_pc;
  logic [WORD_W-1:0]  ex_out;
  logic               ex_br_flag;
  logic [1:0]         ex_mem_op;
  logic [WORD_W-1:0]  ex_mem_wr_data;
  logic [1:0]         ex_ctrl_op;
  logic [4:0]         ex_dst_addr;
  logic               ex_gpr_we_;
  logic [2:0]         ex_exp_code;
  logic [WORD_W-1:0]  fwd_data;
  logic [OFCNT_W-1:0] ofcnt;

  modport master (
    output id_en, id_pc, id_alu_op, alu_out, alu_of, id_br_flag, id_mem_op,
           id_mem_wr_data, id_ctrl_op, id_dst_addr, id_gpr_we_, id_exp_code,
    input  ex_en, ex_pc, ex_out, ex_br_flag, ex_mem_op, ex_mem_wr_data,
           ex_ctrl_op, ex_dst_addr, ex_gpr_we_, ex_exp_code, fwd_data, ofcnt
  );

  modport slave (
    input  id_en, id_pc, id_alu_op, alu_out, alu_of, id_br_flag, id_mem_op,
           id_mem_wr_data, id_ctrl_op, id_dst_addr, id_gpr_we_, id_exp_code,
    output ex_en, ex_pc, ex_out, ex_br_flag, ex_mem_op, ex_mem_wr_data,
           ex_ctrl_op, ex_dst_addr, ex_gpr_we_, ex_exp_code, fwd_data, ofcnt
  );

endinterface

// File: rtl/ex_reg_ofcnt.sv
// Saturating debug counter of overflow exceptions; stall holds it, clr zeroes it.
module ex_ofcnt #(
  parameter int OFCNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               clr,
  input  logic               inc,
  output logic [OFCNT_W-1:0] cnt
);

  // Count overflow events, sticking at all-ones; clear beats increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!stall) begin
      if (clr) begin
        cnt <= '0;
      end else if (inc && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex_reg.sv
// EX/MEM pipeline register: registers the ALU result and EX payload, turns a
// signed overflow into an exception, and inserts bubbles on flush/interrupt.
module ex_reg
  import ex_reg_pkg::*;
#(
  parameter int WORD_W  = ex_reg_pkg::WORD_W,
  parameter int OFCNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        int_detect,
  input  logic        ofcnt_clr,
  ex_reg_if.slave     bus
);

  logic bubble;
  logic ovf;
  logic raise;

  logic       en_p0;
  logic       br_p0;
  logic [1:0] mem_op_p0;
  logic [1:0] ctrl_op_p0;
  logic       gpr_we_p0;
  logic [2:0] exp_code_p0;

  logic              en_p1;
  logic [WORD_W-1:0] pc_p1;
  logic [WORD_W-1:0] out_p1;
  logic              br_p1;
  logic [1:0]        mem_op_p1;
  logic [WORD_W-1:0] mem_wr_data_p1;
  logic [1:0]        ctrl_op_p1;
  logic [4:0]        dst_addr_p1;
  logic              gpr_we_p1;
  logic [2:0]        exp_code_p1;

  logic [OFCNT_W-1:0] ofcnt;

  assign bubble = flush | int_detect;
  assign ovf    = bus.id_en & bus.alu_of & is_signed_arith(bus.id_alu_op);
  // An upstream exception already owns this instruction, so overflow is dropped.
  assign raise  = ovf & (bus.id_exp_code == EXP_NO_EXP);

  // Select the control fields to load: bubble, overflow kill, or pass-through.
  always_comb begin
    en_p0       = bus.id_en;
    br_p0       = bus.id_br_flag;
    mem_op_p0   = bus.id_mem_op;
    ctrl_op_p0  = bus.id_ctrl_op;
    gpr_we_p0   = bus.id_gpr_we_;
    exp_code_p0 = bus.id_exp_code;
    if (bubble) begin
      en_p0       = 1'b0;
      br_p0       = 1'b0;
      mem_op_p0   = MEM_OP_NOP;
      ctrl_op_p0  = CTRL_OP_NOP;
      gpr_we_p0   = 1'b1;
      exp_code_p0 = EXP_NO_EXP;
    end else if (raise) begin
      br_p0       = 1'b0;
      mem_op_p0   = MEM_OP_NOP;
      ctrl_op_p0  = CTRL_OP_NOP;
      gpr_we_p0   = 1'b1;
      exp_code_p0 = EXP_OVERFLOW;
    end
  end

  // EX -> MEM stage boundary; stall freezes everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_p1          <= 1'b0;
      pc_p1          <= '0;
      out_p1         <= '0;
      br_p1          <= 1'b0;
      mem_op_p1      <= MEM_OP_NOP;
      mem_wr_data_p1 <= '0;
      ctrl_op_p1     <= CTRL_OP_NOP;
      dst_addr_p1    <= '0;
      gpr_we_p1      <= 1'b1;
      exp_code_p1    <= EXP_NO_EXP;
    end else if (!stall) begin
      en_p1          <= en_p0;
      pc_p1          <= bus.id_pc;
      out_p1         <= bus.alu_out;
      br_p1          <= br_p0;
      mem_op_p1      <= mem_op_p0;
      mem_wr_data_p1 <= bus.id_mem_wr_data;
      ctrl_op_p1     <= ctrl_op_p0;
      dst_addr_p1    <= bus.id_dst_addr;
      gpr_we_p1      <= gpr_we_p0;
      exp_code_p1    <= exp_code_p0;
    end
  end

  ex_ofcnt #(
    .OFCNT_W(OFCNT_W)
  ) u_ofcnt (
    .clk  (clk),
    .reset(reset),
    .stall(stall),
    .clr  (ofcnt_clr),
    .inc  (raise & ~bubble),
    .cnt  (ofcnt)
  );

  assign bus.ex_en          = en_p1;
  assign bus.ex_pc          = pc_p1;
  assign bus.ex_out         = out_p1;
  assign bus.ex_br_flag     = br_p1;
  assign bus.ex_mem_op      = mem_op_p1;
  assign bus.ex_mem_wr_data = mem_wr_data_p1;
  assign bus.ex_ctrl_op     = ctrl_op_p1;
  assign bus.ex_dst_addr    = dst_addr_p1;
  assign bus.ex_gpr_we_     = gpr_we_p1;
  assign bus.ex_exp_code    = exp_code_p1;
  assign bus.fwd_data       = bus.alu_out;
  assign bus.ofcnt          = ofcnt;

endmodule
